// File: rtl/compressed_sensing_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : compressed_sensing_core_pkg
// Purpose  : Shared constants, types and helpers for the compressed-sensing
//            frame encoder (frame/window sizes, LFSR seed and taps, widths).
// Revision : 1.0 - initial release
// ============================================================================
package compressed_sensing_core_pkg;

    // Frame geometry
    localparam int N_SAMPLES = 96;
    localparam int WIN_LEN   = 12;

    // Sensing sequence: x^16+x^14+x^13+x^11+1, shifted right.
    // The feedback bit is the XOR of state bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Datapath widths
    localparam int SAMPLE_W = 4;
    localparam int MEAS_W   = 4;
    localparam int CNT_W    = 8;
    localparam int ACC_W    = 8;

    localparam logic [ACC_W-1:0] MEAS_MAX = ACC_W'((1 << MEAS_W) - 1);

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [MEAS_W-1:0]   meas_t;
    typedef logic [ACC_W-1:0]    acc_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    // Clamp a window sum to the measurement range.
    function automatic meas_t sat_meas(input acc_t sum);
        meas_t res;
        if (sum > MEAS_MAX) begin
            res = meas_t'(MEAS_MAX);
        end else begin
            res = sum[MEAS_W-1:0];
        end
        return res;
    endfunction

endpackage : compressed_sensing_core_pkg
`default_nettype wire

// File: rtl/compressed_sensing_core_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : cs_lfsr16
// Purpose  : 16-bit Fibonacci LFSR generating the 0/1 sensing sequence phi.
//            Loads SEED on reset, advances one step per enabled clock.
// Revision : 1.0 - initial release
// ============================================================================
module cs_lfsr16
    import compressed_sensing_core_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic sys_clk,
    input  logic sys_reset,
    input  logic step_en,
    output logic phi
);

    logic [15:0] r_state;
    logic        w_feedback;

    assign w_feedback = ^(r_state & LFSR_TAPS);
    assign phi        = r_state[0];

    // Shift right, inserting the feedback bit at the top; reseed on reset.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state <= SEED;
        end else if (step_en) begin
            r_state <= {w_feedback, r_state[15:1]};
        end
    end

endmodule : cs_lfsr16
`default_nettype wire

// File: rtl/compressed_sensing_core.sv
`default_nettype none
// ============================================================================
// Module   : compressed_sensing_core
// Purpose  : Streaming compressed-sensing encoder. Walks a 96-sample frame,
//            accumulates phi-selected samples per 12-sample window and emits a
//            saturated 4-bit measurement per window. Freezes at frame end.
// Revision : 1.0 - initial release
// ============================================================================
module compressed_sensing_core
    import compressed_sensing_core_pkg::*;
#(
    parameter int          N_SAMPLES_P = compressed_sensing_core_pkg::N_SAMPLES,
    parameter int          WIN_LEN_P   = compressed_sensing_core_pkg::WIN_LEN,
    parameter logic [15:0] SEED_P      = compressed_sensing_core_pkg::LFSR_SEED
) (
    input  logic                sys_clk,
    input  logic                sys_reset,
    input  logic [SAMPLE_W-1:0] values,
    output logic [MEAS_W-1:0]   output_symbols,
    output logic [CNT_W-1:0]    value_counter,
    output logic                end_flag
);

    localparam int         WIN_W        = (WIN_LEN_P > 1) ? $clog2(WIN_LEN_P) : 1;
    localparam cnt_t       C_CNT_END    = cnt_t'(N_SAMPLES_P);
    localparam cnt_t       C_CNT_LAST   = cnt_t'(N_SAMPLES_P - 1);
    localparam logic [WIN_W-1:0] C_WIN_LAST = WIN_W'(WIN_LEN_P - 1);

    logic [WIN_W-1:0] r_win_cnt;
    acc_t             r_acc;
    meas_t            r_symbols;
    cnt_t             r_counter;
    logic             r_end_flag;

    logic             w_sample;
    logic             w_phi;
    logic             w_win_last;
    acc_t             w_contrib;
    acc_t             w_sum;

    // A sample is consumed on every edge until the index reaches the frame end.
    assign w_sample   = (r_counter < C_CNT_END);
    assign w_win_last = (r_win_cnt == C_WIN_LAST);
    assign w_contrib  = w_phi ? acc_t'(values) : '0;
    assign w_sum      = r_acc + w_contrib;

    cs_lfsr16 #(
        .SEED      (SEED_P)
    ) u_lfsr (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .step_en   (w_sample),
        .phi       (w_phi)
    );

    // Index counter, window accumulation, measurement register and frame-end flag.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_counter  <= '0;
            r_win_cnt  <= '0;
            r_acc      <= '0;
            r_symbols  <= '0;
            r_end_flag <= 1'b0;
        end else if (w_sample) begin
            r_counter <= r_counter + cnt_t'(1);
            if (r_counter == C_CNT_LAST) begin
                r_end_flag <= 1'b1;
            end
            if (w_win_last) begin
                r_symbols <= sat_meas(w_sum);
                r_acc     <= '0;
                r_win_cnt <= '0;
            end else begin
                r_acc     <= w_sum;
                r_win_cnt <= r_win_cnt + WIN_W'(1);
            end
        end
    end

    assign output_symbols = r_symbols;
    assign value_counter  = r_counter;
    assign end_flag       = r_end_flag;

endmodule : compressed_sensing_core
`default_nettype wire

// File: tb/tb_compressed_sensing_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_compressed_sensing_core
// Purpose  : Self-checking bench for compressed_sensing_core. A frame table plus
//            randomized frames are played through a combinational sample source;
//            every cycle is compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_compressed_sensing_core;

    logic       sys_clk = 1'b0;
    logic       sys_reset = 1'b0;
    logic [3:0] values;
    logic [3:0] output_symbols;
    logic [7:0] value_counter;
    logic       end_flag;

    int checks = 0;
    int errors = 0;

    logic [3:0] frame [96];
    logic [3:0] junk = 4'd0;
    int         exp_meas [8];

    compressed_sensing_core dut (
        .sys_clk        (sys_clk),
        .sys_reset      (sys_reset),
        .values         (values),
        .output_symbols (output_symbols),
        .value_counter  (value_counter),
        .end_flag       (end_flag)
    );

    always #5 sys_clk = ~sys_clk;

    // Sample source: returns frame[index]; past the frame end it returns junk.
    always_comb begin
        values = junk;
        if (int'(value_counter) < 96) values = frame[int'(value_counter)];
    end

    typedef struct {
        string name;
        int    mode;    // 0 zeros, 1 x[0]=1, 2 all 15, 3 given sparse, 4 random sparse, 5 random dense
        int    exp_w0;  // required window-0 measurement, -1 = model only
        int    exp_w1;  // required window-1 measurement, -1 = model only
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: phi from the sensing polynomial, window sums by plain arithmetic.
    task automatic compute_model();
        logic [15:0] s;
        logic        fb;
        int          sums [8];
        s = 16'hACE1;
        for (int w = 0; w < 8; w++) sums[w] = 0;
        for (int n = 0; n < 96; n++) begin
            if (s[0]) sums[n / 12] += int'(frame[n]);
            fb = s[0] ^ s[2] ^ s[3] ^ s[5];
            s  = {fb, s[15:1]};
        end
        for (int w = 0; w < 8; w++) exp_meas[w] = (sums[w] > 15) ? 15 : sums[w];
    endtask

    function automatic int exp_out(input int k);
        int done;
        done = ((k > 96) ? 96 : k) / 12;
        return (done == 0) ? 0 : exp_meas[done - 1];
    endfunction

    // Pull reset low now, check the asynchronous clear, release at the next falling edge.
    task automatic do_reset(input string tag);
        sys_reset = 1'b0;
        #1;
        check({tag, "_rst_counter"}, 32'(value_counter), 0);
        check({tag, "_rst_symbols"}, 32'(output_symbols), 0);
        check({tag, "_rst_end_flag"}, 32'(end_flag), 0);
        @(negedge sys_clk);
        sys_reset = 1'b1;
    endtask

    // Edges first_k..last_k after reset release, checked against the model.
    task automatic run_cycles(input string tag, input int first_k, input int last_k,
                              input int w0, input int w1);
        for (int k = first_k; k <= last_k; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            check({tag, "_counter"}, 32'(value_counter), 32'((k > 96) ? 96 : k));
            check({tag, "_end_flag"}, 32'(end_flag), 32'(k >= 96));
            check({tag, "_symbols"}, 32'(output_symbols), 32'(exp_out(k)));
            if (k == 12 && w0 >= 0) check({tag, "_w0_const"}, 32'(output_symbols), 32'(w0));
            if (k == 24 && w1 >= 0) check({tag, "_w1_const"}, 32'(output_symbols), 32'(w1));
            if (k >= 96) junk = 4'($urandom_range(15, 0));
        end
    endtask

    task automatic fill_frame(input int mode);
        int ones [10] = '{8, 13, 23, 26, 29, 40, 57, 58, 59, 77};
        for (int n = 0; n < 96; n++) frame[n] = 4'd0;
        case (mode)
            1: frame[0] = 4'd1;
            2: for (int n = 0; n < 96; n++) frame[n] = 4'd15;
            3: for (int i = 0; i < 10; i++) frame[ones[i]] = 4'd1;
            4: for (int i = 0; i < 12; i++) frame[$urandom_range(95, 0)] = 4'($urandom_range(15, 1));
            5: for (int n = 0; n < 96; n++) frame[n] = 4'($urandom_range(15, 0));
            default: ;
        endcase
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{"zeros",    0,  0,  0};
        vecs[1] = '{"x0_one",   1,  1,  0};
        vecs[2] = '{"all15",    2, 15, -1};
        vecs[3] = '{"sparse",   3, -1, -1};
        vecs[4] = '{"rnd_sp",   4, -1, -1};
        vecs[5] = '{"rnd_dn",   5, -1, -1};

        fill_frame(0);
        compute_model();
        @(negedge sys_clk);
        do_reset("init");

        for (int v = 0; v < 6; v++) begin
            fill_frame(vecs[v].mode);
            compute_model();
            junk = 4'($urandom_range(15, 0));
            run_cycles(vecs[v].name, 1, 100, vecs[v].exp_w0, vecs[v].exp_w1);
            do_reset({vecs[v].name, "_end"});
        end

        // Abort a dense random frame at index 50, then the next frame must match a fresh run.
        fill_frame(5);
        compute_model();
        run_cycles("abort_pre", 1, 50, -1, -1);
        do_reset("abort");
        run_cycles("abort_post", 1, 98, -1, -1);

        // Looping source: reset in the cycle after end_flag rises, frame repeats identically.
        do_reset("loop_start");
        fill_frame(4);
        compute_model();
        run_cycles("loop_a", 1, 97, -1, -1);
        do_reset("loop");
        run_cycles("loop_b", 1, 97, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_compressed_sensing_core
`default_nettype wire
